// File: rtl/scrypt_salsa_core.sv
// Iterative Salsa20/8 core answering scrypt_blockmix's enable/hash_done handshake.
// Optional: SALSA_DOUBLE_ROUND_EN applies a full double round per clock.
module scrypt_salsa_core #(
   parameter int ROUNDS = 8
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic [511:0] data,
   input  logic         enable,
   output logic [511:0] data_out,
   output logic         hash_done
);

   typedef logic [15:0][31:0] blk_t;
   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_ADD, S_DONE} state_t;

   localparam int CW = $clog2(ROUNDS + 1);
`ifdef SALSA_DOUBLE_ROUND_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [127:0] qr(
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] c, input logic [31:0] d
   );
      logic [31:0] ta, tb, tc, td;
      tb = b ^ rotl(a + d, 7);
      tc = c ^ rotl(tb + a, 9);
      td = d ^ rotl(tc + tb, 13);
      ta = a ^ rotl(td + tc, 18);
      return {ta, tb, tc, td};
   endfunction

   function automatic blk_t col_round(input blk_t x);
      blk_t y;
      y = x;
      {y[0], y[4], y[8], y[12]}  = qr(x[0], x[4], x[8], x[12]);
      {y[5], y[9], y[13], y[1]}  = qr(x[5], x[9], x[13], x[1]);
      {y[10], y[14], y[2], y[6]} = qr(x[10], x[14], x[2], x[6]);
      {y[15], y[3], y[7], y[11]} = qr(x[15], x[3], x[7], x[11]);
      return y;
   endfunction

   function automatic blk_t row_round(input blk_t x);
      blk_t y;
      y = x;
      {y[0], y[1], y[2], y[3]}     = qr(x[0], x[1], x[2], x[3]);
      {y[5], y[6], y[7], y[4]}     = qr(x[5], x[6], x[7], x[4]);
      {y[10], y[11], y[8], y[9]}   = qr(x[10], x[11], x[8], x[9]);
      {y[15], y[12], y[13], y[14]} = qr(x[15], x[12], x[13], x[14]);
      return y;
   endfunction

   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   blk_t          r_x, r_xin;
   blk_t          w_round, w_sum;
   logic          w_last, w_load, w_step, w_add;

`ifdef SALSA_DOUBLE_ROUND_EN
   assign w_round = row_round(col_round(r_x));
`else
   assign w_round = r_cnt[0] ? row_round(r_x) : col_round(r_x);
`endif
   assign w_last = (r_cnt == CW'(ROUNDS - STEP));

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < 16; i++) begin
         w_sum[i] = r_x[i] + r_xin[i];
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Dropping enable in ROUND or ADD abandons the hash without touching data_out.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  w_next = enable ? S_ROUND : S_IDLE;
         S_ROUND: w_next = !enable ? S_IDLE : (w_last ? S_ADD : S_ROUND);
         S_ADD:   w_next = enable ? S_DONE : S_IDLE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      hash_done = (r_state == S_DONE);
      w_load    = (r_state == S_IDLE) && enable;
      w_step    = (r_state == S_ROUND) && enable;
      w_add     = (r_state == S_ADD) && enable;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_cnt    <= '0;
         r_x      <= '0;
         r_xin    <= '0;
         data_out <= '0;
      end else begin
         if (w_load) begin
            r_x   <= data;
            r_xin <= data;
            r_cnt <= '0;
         end else if (w_step) begin
            r_x   <= w_round;
            r_cnt <= r_cnt + CW'(STEP);
         end
         if (w_add) data_out <= w_sum;
      end
   end

endmodule

// File: tb/tb_scrypt_salsa_core.sv
// Scoreboard bench for scrypt_salsa_core: known vectors, reference model,
// back-to-back, aborts and mid-operation reset.
module tb_scrypt_salsa_core;

   localparam int ROUNDS = 8;
`ifdef SALSA_DOUBLE_ROUND_EN
   localparam int LAT = ROUNDS / 2 + 2;
`else
   localparam int LAT = ROUNDS + 2;
`endif

   localparam logic [511:0] RFC_IN =
      512'h5ec2b8b8_8dc6ebed_2948c709_291d0276_32aac55a_4b1e1214_853d9bdf_19f324ee_1d3bcd6d_1146f80d_b5c1618c_5b55eeba_268f7141_e640a97c_86c93e4f_219a877e;
   localparam logic [511:0] RFC_OUT =
      512'h818f61c7_3d67ad24_5c74912c_10cc24e4_ba966da0_b7c56bfe_bce6c9e3_683139b4_292f6896_631c7bfd_7d33fda2_81214b04_05ef0c02_cbca813b_99cc0866_9c851fa4;

   logic         clk = 1'b0;
   logic         n_rst;
   logic [511:0] data;
   logic         enable;
   logic [511:0] data_out;
   logic         hash_done;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [511:0] exp_q[$];
   logic [511:0] last_exp;

   scrypt_salsa_core #(.ROUNDS(ROUNDS)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .data     (data),
      .enable   (enable),
      .data_out (data_out),
      .hash_done(hash_done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rl(input logic [31:0] v, input int n);
      logic [63:0] t;
      t = {v, v} << n;
      return t[63:32];
   endfunction

   function automatic logic [511:0] salsa_ref(input logic [511:0] blk);
      logic [31:0]  x[16];
      logic [31:0]  o[16];
      int           ci[16];
      int           ri[16];
      int           a, b, c, d;
      logic [511:0] res;
      ci = '{0, 4, 8, 12, 5, 9, 13, 1, 10, 14, 2, 6, 15, 3, 7, 11};
      ri = '{0, 1, 2, 3, 5, 6, 7, 4, 10, 11, 8, 9, 15, 12, 13, 14};
      for (int i = 0; i < 16; i++) begin
         x[i] = blk[32*i +: 32];
         o[i] = x[i];
      end
      for (int r = 0; r < ROUNDS; r++) begin
         for (int q = 0; q < 4; q++) begin
            a = (r % 2 == 0) ? ci[4*q]   : ri[4*q];
            b = (r % 2 == 0) ? ci[4*q+1] : ri[4*q+1];
            c = (r % 2 == 0) ? ci[4*q+2] : ri[4*q+2];
            d = (r % 2 == 0) ? ci[4*q+3] : ri[4*q+3];
            x[b] = x[b] ^ rl(x[a] + x[d], 7);
            x[c] = x[c] ^ rl(x[b] + x[a], 9);
            x[d] = x[d] ^ rl(x[c] + x[b], 13);
            x[a] = x[a] ^ rl(x[d] + x[c], 18);
         end
      end
      for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + o[i];
      return res;
   endfunction

   function automatic logic [511:0] rand_blk();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic start_op(input logic [511:0] d, input logic [511:0] e);
      data   = d;
      enable = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(output int cyc, output bit seen);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (hash_done) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      n_rst  = 1'b0;
      enable = 1'b0;
      data   = '0;
      #2;
      n_cmp++;
      if (data_out !== 512'h0 || hash_done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: data_out=%h hash_done=%b want 0/0", data_out, hash_done);
      end
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (hash_done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: hash_done=%b want 0", hash_done);
      end
      last_exp = '0;
   endtask

   task automatic test_vector(input string nm, input logic [511:0] d, input logic [511:0] e);
      int cyc;
      bit seen;
      start_op(d, e);
      wait_done(cyc, seen);
      enable = 1'b0;
      n_cmp++;
      if (!seen || cyc != LAT) begin
         n_bad++;
         $display("FAIL %s_lat: got %0d clocks (seen=%0b) want %0d", nm, cyc, seen, LAT);
      end
      last_exp = exp_q.pop_front();
      n_cmp++;
      if (data_out !== last_exp) begin
         n_bad++;
         $display("FAIL %s_data: got %h want %h", nm, data_out, last_exp);
      end
      @(negedge clk);
      n_cmp++;
      if (hash_done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_pulse: hash_done=%b one clock later, want 0", nm, hash_done);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit seen;
      start_op(RFC_IN, RFC_OUT);
      wait_done(cyc, seen);
      data = '0;
      exp_q.push_back(512'h0);
      n_cmp++;
      if (!seen || cyc != LAT) begin
         n_bad++;
         $display("FAIL b2b_lat1: got %0d clocks (seen=%0b) want %0d", cyc, seen, LAT);
      end
      last_exp = exp_q.pop_front();
      n_cmp++;
      if (data_out !== last_exp) begin
         n_bad++;
         $display("FAIL b2b_data1: got %h want %h", data_out, last_exp);
      end
      wait_done(cyc, seen);
      enable = 1'b0;
      n_cmp++;
      if (!seen || cyc != LAT + 1) begin
         n_bad++;
         $display("FAIL b2b_spacing: got %0d clocks (seen=%0b) want %0d", cyc, seen, LAT + 1);
      end
      last_exp = exp_q.pop_front();
      n_cmp++;
      if (data_out !== last_exp) begin
         n_bad++;
         $display("FAIL b2b_data2: got %h want %h", data_out, last_exp);
      end
      @(negedge clk);
   endtask

   task automatic test_abort(input string nm, input int drop_at);
      logic [511:0] blk;
      int           pulses;
      blk    = rand_blk();
      data   = blk;
      enable = 1'b1;
      repeat (drop_at) @(negedge clk);
      enable = 1'b0;
      data   = '0;
      pulses = 0;
      repeat (LAT + 4) begin
         @(negedge clk);
         if (hash_done) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin
         n_bad++;
         $display("FAIL %s_nopulse: saw %0d pulses want 0", nm, pulses);
      end
      n_cmp++;
      if (data_out !== last_exp) begin
         n_bad++;
         $display("FAIL %s_hold: got %h want %h", nm, data_out, last_exp);
      end
      test_vector({nm, "_retry"}, blk, salsa_ref(blk));
   endtask

   task automatic test_reset_mid();
      data   = rand_blk();
      enable = 1'b1;
      repeat (5) @(negedge clk);
      n_rst  = 1'b0;
      enable = 1'b0;
      #1;
      n_cmp++;
      if (data_out !== 512'h0 || hash_done !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid: data_out=%h hash_done=%b want 0/0", data_out, hash_done);
      end
      last_exp = '0;
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      test_vector("rst_retry", RFC_IN, RFC_OUT);
   endtask

   initial begin
      test_reset();
      test_vector("zero", 512'h0, 512'h0);
      test_vector("rfc", RFC_IN, RFC_OUT);
      for (int k = 0; k < 3; k++) begin
         logic [511:0] b;
         b = rand_blk();
         test_vector("rand", b, salsa_ref(b));
      end
      test_back_to_back();
      test_abort("abort_round", 4);
      test_abort("abort_add", LAT - 1);
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
